// File: rtl/dec_pkg.sv
// Shared definitions for the down_counter_dec slice: FSM encodings,
// default counter width and the all-ones addend used by the decrementer.
package dec_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic [DEF_WIDTH-1:0] ALL_ONES = '1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_RUN  = 2'b01;
    localparam state_t ST_DONE = 2'b10;

endpackage

// File: rtl/down_counter_dec_decrementer.sv
// Combinational WIDTH-bit ripple decrementer: x + all-ones through a chain
// of full-adder cells, the subtract-one twin of the incrementer datapath.
module decrementer
    import dec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    localparam logic [WIDTH-1:0] ADDEND = {WIDTH{ALL_ONES[0]}};

    logic [WIDTH:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign d[i]   = x[i] ^ ADDEND[i] ^ c[i];
        assign c[i+1] = (x[i] & ADDEND[i]) | (c[i] & (x[i] ^ ADDEND[i]));
    end

    // Adding all-ones carries out for every x except 0, so the borrow is
    // the inverted final carry.
    assign bo = ~c[WIDTH];

endmodule

// File: rtl/down_counter_dec.sv
// Loadable, enable-gated down-counter with IDLE/RUN/DONE control.
// Define DOWN_COUNTER_WRAP_EN for free-running wrap mode with a borrow pulse.
module down_counter_dec
    import dec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] dec_d;
    logic             dec_bo;

`ifdef DOWN_COUNTER_WRAP_EN
    logic done_q;
    logic done_nxt;
    logic borrow_q;
    logic borrow_nxt;
`endif

    decrementer #(
        .WIDTH (WIDTH)
    ) u_dec (
        .x  (count),
        .d  (dec_d),
        .bo (dec_bo)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        count_nxt = count;
`ifdef DOWN_COUNTER_WRAP_EN
        done_nxt   = 1'b0;
        borrow_nxt = 1'b0;
`endif
        if (load) begin
            count_nxt = load_val;
`ifdef DOWN_COUNTER_WRAP_EN
            state_nxt = (load_val == '0) ? ST_IDLE : ST_RUN;
`else
            state_nxt = (load_val == '0) ? ST_DONE : ST_RUN;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_IDLE;
                end
                ST_RUN: begin
                    if (en) begin
`ifdef DOWN_COUNTER_WRAP_EN
                        count_nxt  = dec_d;
                        borrow_nxt = dec_bo;
                        done_nxt   = (count == ONE);
`else
                        // Never step through zero outside wrap mode.
                        if (!dec_bo) begin
                            count_nxt = dec_d;
                        end
                        if (count == ONE) begin
                            state_nxt = ST_DONE;
                        end
`endif
                    end
                end
`ifdef DOWN_COUNTER_WRAP_EN
                // DONE does not exist in wrap mode; treat it as illegal.
                default: begin
                    state_nxt = ST_IDLE;
                end
`else
                ST_DONE: begin
                    state_nxt = ST_DONE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
`endif
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
`ifdef DOWN_COUNTER_WRAP_EN
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            count <= count_nxt;
`ifdef DOWN_COUNTER_WRAP_EN
            done_q   <= done_nxt;
            borrow_q <= borrow_nxt;
`endif
        end
    end

    assign busy = (state == ST_RUN);
    assign zero = (count == '0);

`ifdef DOWN_COUNTER_WRAP_EN
    assign done   = done_q;
    assign borrow = borrow_q;
`else
    assign done   = (state == ST_DONE);
    assign borrow = 1'b0;
`endif

endmodule
